// File: rtl/csi_packet_parser.sv
// rtl/csi_packet_parser.sv - CSI-2 packet header parser and RAW payload forwarder
//
// Purpose: parses CSI-2 packet headers from the merged 32-bit receiver word
// stream. Payload words of the accepted long data type are forwarded with
// byte enables. Frame, line and error strobes are emitted, and the frame
// number and line index are tracked for the RAM address generator.
//
// Ports:
//   sys_clk      in   1   system clock
//   reset        in   1   synchronous, active-high
//   in_valid     in   1   in_data valid this cycle
//   in_sop       in   1   first word after HS sync (packet header)
//   in_data      in  32   received word, [7:0] first on the wire
//   pix_valid    out  1   payload word valid
//   pix_data     out 32   payload word
//   pix_be       out  4   byte enables (partial only on the last word)
//   pix_last     out  1   last payload word of the packet
//   frame_start  out  1   FS short packet pulse
//   frame_end    out  1   FE short packet pulse
//   line_start   out  1   accepted long header pulse
//   frame_num    out 16   WC field of the last FS
//   line_idx     out 16   current/next accepted line within the frame
//   trunc_err    out  1   sop arrived before the payload finished
//   len_err      out  1   long header with WC > MAX_WC
module csi_packet_parser #(
  parameter logic [5:0]  ACCEPT_DT = 6'h2B,
  parameter logic [15:0] MAX_WC    = 16'd4096
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_sop,
  input  logic [31:0] in_data,
  output logic        pix_valid,
  output logic [31:0] pix_data,
  output logic [3:0]  pix_be,
  output logic        pix_last,
  output logic        frame_start,
  output logic        frame_end,
  output logic        line_start,
  output logic [15:0] frame_num,
  output logic [15:0] line_idx,
  output logic        trunc_err,
  output logic        len_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    SKIP    = 2'd2
  } state_t;

  state_t      state, state_d;
  logic [15:0] rem, rem_d;

  // Header fields; VC (in_data[7:6]) and ECC (in_data[31:24]) are ignored.
  logic [5:0]  hdr_dt;
  logic [15:0] hdr_wc;
  logic        hdr_seen;
  logic        hdr_short;
  logic        hdr_too_long;
  logic        hdr_accept;
  logic        pay_word;
  logic        pay_end;

  assign hdr_dt       = in_data[5:0];
  assign hdr_wc       = in_data[23:8];
  assign hdr_seen     = in_valid && in_sop;
  assign hdr_short    = (hdr_dt < 6'h10);
  assign hdr_too_long = !hdr_short && (hdr_wc > MAX_WC);
  assign hdr_accept   = !hdr_short && !hdr_too_long && (hdr_dt == ACCEPT_DT);
  assign pay_word     = in_valid && !in_sop && (state == PAYLOAD);
  assign pay_end      = (rem <= 16'd4);

  // Next-value signals for the registered outputs
  logic        pix_valid_d;
  logic [31:0] pix_data_d;
  logic [3:0]  pix_be_d;
  logic        pix_last_d;
  logic        frame_start_d;
  logic        frame_end_d;
  logic        line_start_d;
  logic [15:0] frame_num_d;
  logic [15:0] line_idx_d;
  logic        trunc_err_d;
  logic        len_err_d;

  // State register and output registers
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state       <= IDLE;
      rem         <= 16'd0;
      pix_valid   <= 1'b0;
      pix_data    <= 32'd0;
      pix_be      <= 4'd0;
      pix_last    <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      line_start  <= 1'b0;
      frame_num   <= 16'd0;
      line_idx    <= 16'd0;
      trunc_err   <= 1'b0;
      len_err     <= 1'b0;
    end else begin
      state       <= state_d;
      rem         <= rem_d;
      pix_valid   <= pix_valid_d;
      pix_data    <= pix_data_d;
      pix_be      <= pix_be_d;
      pix_last    <= pix_last_d;
      frame_start <= frame_start_d;
      frame_end   <= frame_end_d;
      line_start  <= line_start_d;
      frame_num   <= frame_num_d;
      line_idx    <= line_idx_d;
      trunc_err   <= trunc_err_d;
      len_err     <= len_err_d;
    end
  end

  // Next-state logic; a sop word is always a header, whatever the state
  always_comb begin
    state_d = state;
    rem_d   = rem;
    if (hdr_seen) begin
      if (hdr_short) begin
        state_d = IDLE;
      end else if (hdr_accept && (hdr_wc != 16'd0)) begin
        state_d = PAYLOAD;
        rem_d   = hdr_wc;
      end else begin
        state_d = SKIP;
      end
    end else if (pay_word) begin
      if (pay_end) begin
        state_d = SKIP;   // trailing CRC / padding is dropped
      end else begin
        rem_d = rem - 16'd4;
      end
    end
  end

  // Output logic (values registered on the next edge)
  always_comb begin
    pix_valid_d   = 1'b0;
    pix_data_d    = 32'd0;
    pix_be_d      = 4'd0;
    pix_last_d    = 1'b0;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
    line_start_d  = 1'b0;
    frame_num_d   = frame_num;
    line_idx_d    = line_idx;
    trunc_err_d   = 1'b0;
    len_err_d     = 1'b0;

    if (hdr_seen) begin
      // An interrupted payload is abandoned without pix_last or a line count
      trunc_err_d = (state == PAYLOAD);
      if (hdr_short) begin
        if (hdr_dt == 6'h00) begin
          frame_start_d = 1'b1;
          frame_num_d   = hdr_wc;
          line_idx_d    = 16'd0;
        end else if (hdr_dt == 6'h01) begin
          frame_end_d = 1'b1;
        end
      end else if (hdr_too_long) begin
        len_err_d = 1'b1;
      end else if (hdr_accept) begin
        line_start_d = 1'b1;
        // An empty accepted line completes immediately
        if (hdr_wc == 16'd0) begin
          line_idx_d = line_idx + 16'd1;
        end
      end
    end else if (pay_word) begin
      pix_valid_d = 1'b1;
      pix_data_d  = in_data;
      if (pay_end) begin
        pix_last_d = 1'b1;
        line_idx_d = line_idx + 16'd1;
        // rem is 1..4 here; anything not 1..3 is a full word
        case (rem[2:0])
          3'd1:    pix_be_d = 4'b0001;
          3'd2:    pix_be_d = 4'b0011;
          3'd3:    pix_be_d = 4'b0111;
          default: pix_be_d = 4'b1111;
        endcase
      end else begin
        pix_be_d = 4'hF;
      end
    end
  end

endmodule

// File: tb/tb_csi_packet_parser.sv
// tb/tb_csi_packet_parser.sv - directed self-checking bench for csi_packet_parser
module tb_csi_packet_parser;

  logic        sys_clk;
  logic        reset;
  logic        in_valid;
  logic        in_sop;
  logic [31:0] in_data;
  logic        pix_valid;
  logic [31:0] pix_data;
  logic [3:0]  pix_be;
  logic        pix_last;
  logic        frame_start;
  logic        frame_end;
  logic        line_start;
  logic [15:0] frame_num;
  logic [15:0] line_idx;
  logic        trunc_err;
  logic        len_err;

  int n_checks;
  int n_errors;

  csi_packet_parser dut (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_sop      (in_sop),
    .in_data     (in_data),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .pix_be      (pix_be),
    .pix_last    (pix_last),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .line_start  (line_start),
    .frame_num   (frame_num),
    .line_idx    (line_idx),
    .trunc_err   (trunc_err),
    .len_err     (len_err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one input word, clock it in, then sample the registered result
  task automatic send(input logic v, input logic s, input logic [31:0] d);
    @(negedge sys_clk);
    in_valid = v;
    in_sop   = s;
    in_data  = d;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check_strobes(input string tag, input logic [5:0] exp);
    check(tag, {26'd0, frame_start, frame_end, line_start, trunc_err, len_err, pix_valid},
          {26'd0, exp});
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_data  = 32'd0;
    repeat (2) @(posedge sys_clk);
    #1;
    check_strobes("rst_strobes", 6'b000000);
    check("rst_pix_data", pix_data, 32'd0);
    check("rst_pix_be", {28'd0, pix_be}, 32'd0);
    check("rst_pix_last", {31'd0, pix_last}, 32'd0);
    check("rst_frame_num", {16'd0, frame_num}, 32'd0);
    check("rst_line_idx", {16'd0, line_idx}, 32'd0);
    @(negedge sys_clk);
    reset = 1'b0;

    // sop without valid is ignored
    send(1'b0, 1'b1, 32'h0000_0500);
    check_strobes("sop_no_valid", 6'b000000);

    // FS, WC=5; strobe order: fs fe ls trunc len pix
    send(1'b1, 1'b1, 32'h0000_0500);
    check_strobes("fs_pulse", 6'b100000);
    check("fs_frame_num", {16'd0, frame_num}, 32'd5);
    check("fs_line_idx", {16'd0, line_idx}, 32'd0);
    send(1'b0, 1'b0, 32'd0);
    check_strobes("fs_one_cycle", 6'b000000);

    // RAW10, WC=10: be F, F, 3 then a dropped word
    send(1'b1, 1'b1, 32'h0000_0A2B);
    check_strobes("l1_hdr", 6'b001000);
    send(1'b1, 1'b0, 32'h1111_1111);
    check_strobes("l1_w1", 6'b000001);
    check("l1_w1_data", pix_data, 32'h1111_1111);
    check("l1_w1_be", {28'd0, pix_be}, 32'hF);
    send(1'b0, 1'b0, 32'hDEAD_BEEF);
    check_strobes("l1_gap", 6'b000000);
    send(1'b1, 1'b0, 32'h2222_2222);
    check("l1_w2_be", {27'd0, pix_valid, pix_be}, 32'h1F);
    check("l1_w2_last", {31'd0, pix_last}, 32'd0);
    send(1'b1, 1'b0, 32'h3333_3333);
    check("l1_w3_be", {27'd0, pix_valid, pix_be}, 32'h13);
    check("l1_w3_last", {31'd0, pix_last}, 32'd1);
    check("l1_w3_data", pix_data, 32'h3333_3333);
    check("l1_line_idx", {16'd0, line_idx}, 32'd1);
    send(1'b1, 1'b0, 32'h4444_4444);
    check_strobes("l1_w4_dropped", 6'b000000);

    // RAW8, WC=8: discarded
    send(1'b1, 1'b1, 32'h0000_082A);
    check_strobes("raw8_hdr", 6'b000000);
    send(1'b1, 1'b0, 32'h5555_5555);
    check_strobes("raw8_w1", 6'b000000);
    send(1'b1, 1'b0, 32'h6666_6666);
    check_strobes("raw8_w2", 6'b000000);
    check("raw8_line_idx", {16'd0, line_idx}, 32'd1);

    // WC=16 truncated by FE after two words
    send(1'b1, 1'b1, 32'h0000_102B);
    check_strobes("tr_hdr", 6'b001000);
    send(1'b1, 1'b0, 32'h7777_7777);
    send(1'b1, 1'b0, 32'h8888_8888);
    check("tr_w2_be", {27'd0, pix_valid, pix_be}, 32'h1F);
    send(1'b1, 1'b1, 32'h0000_0001);
    check_strobes("tr_fe_trunc", 6'b010100);
    check("tr_no_last", {31'd0, pix_last}, 32'd0);
    check("tr_line_idx", {16'd0, line_idx}, 32'd1);
    check("tr_frame_num", {16'd0, frame_num}, 32'd5);
    send(1'b1, 1'b0, 32'h9999_9999);
    check_strobes("tr_after_idle", 6'b000000);

    // WC=5000 rejected
    send(1'b1, 1'b1, 32'h0013_882B);
    check_strobes("len_hdr", 6'b000010);
    send(1'b1, 1'b0, 32'hAAAA_AAAA);
    check_strobes("len_w1", 6'b000000);

    // WC=4096 (limit) is accepted; aborted by a RAW10 header (trunc + line_start)
    send(1'b1, 1'b1, 32'h0010_002B);
    check_strobes("max_hdr", 6'b001000);
    send(1'b1, 1'b0, 32'hBBBB_BBBB);
    check_strobes("max_w1", 6'b000001);

    // WC=0 aborting the above: trunc, line_start, line_idx+1, no pixels
    send(1'b1, 1'b1, 32'h0000_002B);
    check_strobes("wc0_hdr", 6'b001100);
    check("wc0_line_idx", {16'd0, line_idx}, 32'd2);
    send(1'b1, 1'b0, 32'hCCCC_CCCC);
    check_strobes("wc0_w1", 6'b000000);

    // WC=5: be F then 1
    send(1'b1, 1'b1, 32'h0000_052B);
    send(1'b1, 1'b0, 32'h0102_0304);
    check("wc5_w1_be", {26'd0, pix_last, pix_valid, pix_be}, 32'h1F);
    send(1'b1, 1'b0, 32'h0506_0708);
    check("wc5_w2_be", {26'd0, pix_last, pix_valid, pix_be}, 32'h31);
    check("wc5_line_idx", {16'd0, line_idx}, 32'd3);

    // Reset during a WC=64 payload with in_valid held high
    send(1'b1, 1'b1, 32'h0000_402B);
    send(1'b1, 1'b0, 32'hD0D0_D0D0);
    check_strobes("rp_w1", 6'b000001);
    @(negedge sys_clk);
    reset    = 1'b1;
    in_valid = 1'b1;
    in_sop   = 1'b0;
    in_data  = 32'hE0E0_E0E0;
    @(posedge sys_clk);
    #1;
    check_strobes("rp_rst_strobes", 6'b000000);
    check("rp_rst_data", pix_data, 32'd0);
    check("rp_rst_be", {28'd0, pix_be}, 32'd0);
    check("rp_rst_frame_num", {16'd0, frame_num}, 32'd0);
    check("rp_rst_line_idx", {16'd0, line_idx}, 32'd0);
    @(negedge sys_clk);
    reset = 1'b0;
    send(1'b1, 1'b0, 32'hF0F0_F0F0);
    check_strobes("rp_after1", 6'b000000);
    send(1'b1, 1'b0, 32'hF1F1_F1F1);
    check_strobes("rp_after2", 6'b000000);

    // Next sop resumes: WC=4 gives a single full last word
    send(1'b1, 1'b1, 32'h0000_042B);
    check_strobes("wc4_hdr", 6'b001000);
    send(1'b1, 1'b0, 32'h1234_5678);
    check("wc4_w1", {26'd0, pix_last, pix_valid, pix_be}, 32'h3F);
    check("wc4_line_idx", {16'd0, line_idx}, 32'd1);

    send(1'b0, 1'b0, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/csi_packet_parser.md
# csi_packet_parser

Stage between the MIPI receiver and the frame-buffer writer. It takes the receiver's 32-bit word stream (two lanes merged, byte-aligned after sync detection) and parses CSI-2 packet headers. It forwards payload words of one accepted long-packet data type with byte enables, emits frame, line and error strobes, and tracks frame number and line index for the RAM address generator.

## Interface
Parameters:
- ACCEPT_DT, 6'h2B, long-packet data type forwarded (RAW10); other long types are discarded.
- MAX_WC, 16'd4096, largest legal word count in bytes; larger values are rejected.

Ports:
- sys_clk  in  1  system clock (100 MHz); single clock domain.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  in_data carries a valid word this cycle.
- in_sop  in  1  with in_valid: this word is the first word after an HS sync, i.e. the packet header.
- in_data  in  32  wire byte order: [7:0] first, [31:24] last.
- pix_valid  out  1  payload word valid.
- pix_data  out  32  payload word, same byte order as in_data.
- pix_be  out  4  byte enables; 4'hF except on the last word.
- pix_last  out  1  last payload word of the packet.
- frame_start  out  1  one-cycle pulse on FS short packet.
- frame_end  out  1  one-cycle pulse on FE short packet.
- line_start  out  1  one-cycle pulse when an accepted long-packet header is parsed.
- frame_num  out  16  WC field latched from the last FS.
- line_idx  out  16  index of the current/next accepted line within the frame.
- trunc_err  out  1  one-cycle pulse: new sop arrived before the payload finished.
- len_err  out  1  one-cycle pulse: header WC > MAX_WC.

## Operation
- Header word fields: DI = in_data[7:0] (DT = DI[5:0], VC = DI[7:6] ignored), WC = in_data[23:8], ECC = in_data[31:24] (not checked; CRC not checked).
- States:
  - IDLE: wait for in_valid & in_sop.
  - PAYLOAD: forwarding an accepted packet.
  - SKIP: ignore words until the next sop.
- Any in_valid & in_sop is decoded as a header regardless of state.
- Short packets (DT < 6'h10):
  - DT 0x00 (FS): pulse frame_start, frame_num <= WC, line_idx <= 0.
  - DT 0x01 (FE): pulse frame_end.
  - Other short types: no strobe.
  - Next state after any short packet: IDLE.
- Long packet, DT == ACCEPT_DT, WC ≤ MAX_WC, WC > 0:
  - Pulse line_start.
  - Load rem = WC (16-bit unsigned); go to PAYLOAD.
- Long packet, DT == ACCEPT_DT, WC == 0: pulse line_start, increment line_idx, go to SKIP. No pix output.
- Long packet, DT ≠ ACCEPT_DT: go to SKIP; no strobes.
- WC > MAX_WC, any long DT: pulse len_err, go to SKIP.
- PAYLOAD, each in_valid word without sop:
  - If rem > 4: pix_valid, pix_be = 4'hF, rem -= 4.
  - If rem ≤ 4: pix_valid, pix_last, pix_be = (1<<rem)-1 (rem 1→0001, 2→0011, 3→0111, 4→1111); increment line_idx; go to SKIP (trailing CRC/junk dropped).
- Sop in PAYLOAD: pulse trunc_err; do not emit pix_last; do not increment line_idx; decode the sop word as a new header in the same cycle.
- line_idx wraps 16'hFFFF → 0. Frame_num is unchanged by FE.
- in_valid low: no state change; in_sop without in_valid is ignored.

## Timing
- All outputs registered: one-cycle latency from the input word to pix_* and to strobes.
- Throughput: one word per cycle, no backpressure; the downstream stage must accept every pix_valid.
- Reset values: pix_valid, pix_last, all strobes and errors = 0; pix_data = 0; pix_be = 0; frame_num = 0; line_idx = 0; state = IDLE.
- Reset asserted mid-packet: next cycle all outputs are at reset values and the rest of the packet is ignored until a sop.
- The header word itself never produces pix_valid.
- trunc_err and line_start can pulse in the same cycle (abort plus new accepted header).

## Test plan
- Reset, then FS header 32'hxx_0005_00 → frame_start = 1 for exactly one cycle, 1 cycle after the header; frame_num = 5; line_idx = 0.
- Header DT 0x2B, WC = 10, followed by 4 words → line_start, then 3 pix_valid with be F, F, 3; pix_last on the third; 4th word dropped; line_idx = 1.
- Header DT 0x2A (RAW8), WC = 8, 2 words → no pix_valid and no strobes; line_idx unchanged.
- Header 0x2B, WC = 16, with a sop after 2 payload words carrying an FE header → trunc_err and frame_end pulse in the same cycle; no pix_last; line_idx unchanged.
- Header 0x2B, WC = 5000 → len_err pulse; following words produce no output. WC = 0 → line_start, line_idx + 1, no pix output.
- Assert reset during a WC = 64 payload with in_valid held high → all outputs 0 the next cycle; no output until the next sop.
